// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and a small magnitude helper.
package muldiv_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } md_state_e;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iteration datapath: 64-bit working register, step counter and one
// shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module md_iter_core
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        is_div,
    input  logic        step_en,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] work,
    output logic        done
);

    logic [63:0] work_q, work_d;
    logic [31:0] opnd_q;
    logic [4:0]  count_q;
    logic [32:0] add_sum;
    logic [32:0] sub_diff;

    always_comb begin
        add_sum  = {1'b0, work_q[63:32]} + {1'b0, (work_q[0] ? opnd_q : 32'd0)};
        // Bit 32 set means the shifted remainder is below the divisor.
        sub_diff = work_q[63:31] - {1'b0, opnd_q};
        work_d   = work_q;
        if (is_div) begin
            work_d = sub_diff[32] ? {work_q[62:0], 1'b0}
                                  : {sub_diff[31:0], work_q[30:0], 1'b1};
        end else begin
            work_d = {add_sum, work_q[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q  <= 64'd0;
            opnd_q  <= 32'd0;
            count_q <= 5'd0;
        end else if (load) begin
            work_q  <= {32'd0, a_mag};
            opnd_q  <= b_mag;
            count_q <= 5'd0;
        end else if (step_en) begin
            work_q  <= work_d;
            count_q <= count_q + 5'd1;
        end
    end

    assign work = work_q;
    assign done = (count_q == 5'd31);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers,
// sign correction on commit and a stall request for dependent instructions.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    input  logic        mf_req_i,
    input  logic        mf_sel_i,
    output logic [31:0] mf_data_o,
    output logic        busy_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    md_state_e   state_q, state_d;
    logic [31:0] hi_q, lo_q;
    logic        sa_q, sb_q, is_div_q, div_zero_q;
    logic [31:0] a_raw_q;

    logic        accept, md_start, signed_op, step_en, done;
    logic [63:0] work;
    logic [63:0] mul_res;
    logic [31:0] div_lo, div_hi;

    assign accept    = (state_q == StIdle) && start_i && !flush_i;
    assign md_start  = accept && (op_i <= MD_DIVU);
    assign signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);

    md_iter_core u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (md_start),
        .is_div  (is_div_q),
        .step_en (step_en),
        .a_mag   (signed_op ? abs32(a_i) : a_i),
        .b_mag   (signed_op ? abs32(b_i) : b_i),
        .work    (work),
        .done    (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (md_start) state_d = StCalc;
            StCalc: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (done) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o    = (state_q != StIdle);
        stall_o   = busy_o && (start_i || mf_req_i);
        mf_data_o = mf_sel_i ? hi_q : lo_q;
        step_en   = (state_q == StCalc);
    end

    always_comb begin
        mul_res = (sa_q ^ sb_q) ? (~work + 64'd1) : work;
        div_lo  = (sa_q ^ sb_q) ? (~work[31:0] + 32'd1) : work[31:0];
        div_hi  = sa_q ? (~work[63:32] + 32'd1) : work[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= 32'd0;
        end else if (md_start) begin
            sa_q       <= signed_op && a_i[31];
            sb_q       <= signed_op && b_i[31];
            is_div_q   <= (op_i == MD_DIV) || (op_i == MD_DIVU);
            div_zero_q <= (b_i == 32'd0);
            a_raw_q    <= a_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (accept && op_i == MD_MTHI) begin
            hi_q <= a_i;
        end else if (accept && op_i == MD_MTLO) begin
            lo_q <= a_i;
        end else if (state_q == StFix && !flush_i) begin
            if (!is_div_q) begin
                {hi_q, lo_q} <= mul_res;
            end else if (div_zero_q) begin
                hi_q <= a_raw_q;
                lo_q <= 32'hFFFF_FFFF;
            end else begin
                hi_q <= div_hi;
                lo_q <= div_lo;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
